switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer_pkg.sv | 23 ++
 rtl/switch_debouncer_if.sv | 24 ++
 rtl/switch_debouncer_debounce_cell.sv | 73 +++++++
 rtl/switch_debouncer.sv | 66 ++++++
 tb/tb_switch_debouncer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the 18-bit toggle-switch debouncer.
package switch_debouncer_pkg;

    localparam int unsigned NUM_SWITCHES           = 18;
    localparam int unsigned DEFAULT_CLOCK_DIV      = 50000;
    localparam int unsigned DEFAULT_STABLE_SAMPLES = 4;

    // What a sample instant does to one switch bit.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,  // not a sample instant
        ACT_CLEAR  = 2'd1,  // sample agrees with the debounced level
        ACT_COUNT  = 2'd2,  // sample differs, run not yet long enough
        ACT_COMMIT = 2'd3   // sample differs for the last required time
    } cell_action_e;

    // Registered per-bit outputs.
    typedef struct packed {
        logic db;
        logic rise;
        logic fall;
    } cell_out_t;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side signal bundle: raw levels in, debounced levels, edge pulses
// and the sample strobe out.
interface switch_debouncer_if;
    import switch_debouncer_pkg::*;

    logic [NUM_SWITCHES-1:0] sw;
    logic [NUM_SWITCHES-1:0] sw_db;
    logic [NUM_SWITCHES-1:0] sw_rise;
    logic [NUM_SWITCHES-1:0] sw_fall;
    logic                    sample_tick;

    // Master drives the raw switches and consumes the debounced view.
    modport master (
        output sw,
        input  sw_db, sw_rise, sw_fall, sample_tick
    );

    // Slave is the debouncer itself.
    modport slave (
        input  sw,
        output sw_db, sw_rise, sw_fall, sample_tick
    );

endinterface

// File: rtl/switch_debouncer_debounce_cell.sv
// One switch bit: stability counter, debounced level and edge pulses.
// The level only changes after STABLE_SAMPLES consecutive sample instants
// that all disagree with it; any agreeing sample restarts the run.
module debounce_cell
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic sample,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    cell_out_t        out_q, out_d;
    cell_action_e     action;

    // Decide what the current cycle does to this bit.
    always_comb begin
        action = ACT_HOLD;
        if (sample_tick) begin
            if (sample == out_q.db) begin
                action = ACT_CLEAR;
            end else if (cnt_q == CNT_LAST) begin
                action = ACT_COMMIT;
            end else begin
                action = ACT_COUNT;
            end
        end
    end

    // Next counter and output values; pulses default low so they last one cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        out_d = '{db: out_q.db, rise: 1'b0, fall: 1'b0};
        unique case (action)
            ACT_CLEAR:  cnt_d = '0;
            ACT_COUNT:  cnt_d = cnt_q + CNT_W'(1);
            ACT_COMMIT: begin
                cnt_d      = '0;
                out_d.db   = sample;
                out_d.rise = sample;
                out_d.fall = ~sample;
            end
            default:    ;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign db   = out_q.db;
    assign rise = out_q.rise;
    assign fall = out_q.fall;

endmodule

// File: rtl/switch_debouncer.sv
// 18-bit toggle-switch debouncer: shared two-flop synchronizer and sample
// prescaler feeding one debounce_cell per switch. All outputs are flops.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned CLOCK_DIV      = DEFAULT_CLOCK_DIV,
    parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
    input  logic                    CLOCK_50_I,
    input  logic                    RESETN_I,
    input  logic [NUM_SWITCHES-1:0] SWITCH_I,
    output logic [NUM_SWITCHES-1:0] SWITCH_DB_O,
    output logic [NUM_SWITCHES-1:0] SWITCH_RISE_O,
    output logic [NUM_SWITCHES-1:0] SWITCH_FALL_O,
    output logic                    SAMPLE_TICK_O
);

    localparam int unsigned      DIV_W    = $clog2(CLOCK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV - 1);

    logic [NUM_SWITCHES-1:0] sync1_q, sync1_d;
    logic [NUM_SWITCHES-1:0] sync2_q, sync2_d;
    logic [DIV_W-1:0]        presc_q, presc_d;
    logic                    tick_q,  tick_d;

    // Synchronizer shift, prescaler wrap and a tick registered in step with the last count.
    always_comb begin
        sync1_d = SWITCH_I;
        sync2_d = sync1_q;
        presc_d = (presc_q == DIV_LAST) ? '0 : presc_q + DIV_W'(1);
        tick_d  = (presc_d == DIV_LAST);
    end

    // Shared front-end registers.
    always_ff @(posedge CLOCK_50_I) begin
        if (!RESETN_I) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign SAMPLE_TICK_O = tick_q;

    // Independent per-switch debounce logic.
    for (genvar gi = 0; gi < NUM_SWITCHES; gi++) begin : g_cell
        debounce_cell #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_cell (
            .clk         (CLOCK_50_I),
            .rst_n       (RESETN_I),
            .sample_tick (tick_q),
            .sample      (sync2_q[gi]),
            .db          (SWITCH_DB_O[gi]),
            .rise        (SWITCH_RISE_O[gi]),
            .fall        (SWITCH_FALL_O[gi])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with CLOCK_DIV=4, STABLE_SAMPLES=3.
module tb_switch_debouncer;

    localparam int DIV = 4;
    localparam int SS  = 3;
    localparam int NSW = 18;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    switch_debouncer_if sif ();

    switch_debouncer #(
        .CLOCK_DIV      (DIV),
        .STABLE_SAMPLES (SS)
    ) dut (
        .CLOCK_50_I    (clk),
        .RESETN_I      (rstn),
        .SWITCH_I      (sif.sw),
        .SWITCH_DB_O   (sif.sw_db),
        .SWITCH_RISE_O (sif.sw_rise),
        .SWITCH_FALL_O (sif.sw_fall),
        .SAMPLE_TICK_O (sif.sample_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from histories: the raw input seen at every edge, and the
    // synchronized sample taken at every sample instant. A bit changes when
    // the last SS samples all disagree with it and all came after its
    // previous change.
    int unsigned    mdl_m;                  // edges since reset release
    logic [NSW-1:0] in_hist[$];             // SWITCH_I at edge e is in_hist[e-1]
    logic [NSW-1:0] tick_samp[$];           // sample seen at the n-th tick
    int             last_flip[NSW];         // tick index of last change
    logic [NSW-1:0] mdl_db, mdl_rise, mdl_fall;
    logic           mdl_tick;

    task automatic model_edge(input logic rn, input logic [NSW-1:0] sw);
        logic [NSW-1:0] samp;
        int             n;
        bit             all_diff;
        if (!rn) begin
            mdl_m = 0;
            in_hist.delete();
            tick_samp.delete();
            foreach (last_flip[b]) last_flip[b] = -1;
            mdl_db = '0; mdl_rise = '0; mdl_fall = '0; mdl_tick = 1'b0;
        end else begin
            mdl_rise = '0;
            mdl_fall = '0;
            // The cycle ending now follows edge mdl_m; it is a sample instant
            // when the prescaler (mdl_m mod DIV) sits at DIV-1. Its synchronized
            // value is the raw input two edges back.
            if (mdl_m % DIV == DIV - 1) begin
                samp = (mdl_m >= 2) ? in_hist[mdl_m - 2] : '0;
                tick_samp.push_back(samp);
                n = tick_samp.size() - 1;
                for (int b = 0; b < NSW; b++) begin
                    if (n >= SS - 1 && n - SS + 1 > last_flip[b]) begin
                        all_diff = 1'b1;
                        for (int j = n - SS + 1; j <= n; j++)
                            if (tick_samp[j][b] == mdl_db[b]) all_diff = 1'b0;
                        if (all_diff) begin
                            mdl_db[b]    = ~mdl_db[b];
                            last_flip[b] = n;
                            if (mdl_db[b]) mdl_rise[b] = 1'b1;
                            else           mdl_fall[b] = 1'b1;
                        end
                    end
                end
            end
            in_hist.push_back(sw);
            mdl_m++;
            mdl_tick = (mdl_m % DIV == DIV - 1);
        end
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge(rstn, sif.sw);
        @(negedge clk);
        check("mdl_db",   sif.sw_db,       mdl_db);
        check("mdl_rise", sif.sw_rise,     mdl_rise);
        check("mdl_fall", sif.sw_fall,     mdl_fall);
        check("mdl_tick", sif.sample_tick, mdl_tick);
        check("rise_and_fall_overlap", sif.sw_rise & sif.sw_fall, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_db"},   sif.sw_db,       '0);
        check({tag, "_rise"}, sif.sw_rise,     '0);
        check({tag, "_fall"}, sif.sw_fall,     '0);
        check({tag, "_tick"}, sif.sample_tick, '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NSW-1:0] sw;
        int             hold;
        logic [NSW-1:0] exp_db;
        logic [NSW-1:0] exp_rise;
        logic [NSW-1:0] exp_fall;
        int             exp_changes;
    } vec_t;

    vec_t vecs[7];

    logic bnc_db_seen, bnc_pulse_seen;

    task automatic bounce_phase(input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            sif.sw[5] = val;
            step();
            bnc_db_seen    |= sif.sw_db[5];
            bnc_pulse_seen |= (|sif.sw_rise) | (|sif.sw_fall);
        end
    endtask

    initial begin
        logic [NSW-1:0] rise_or, fall_or, prev_db, others_or;
        int             changes, pulses, lat, rise_cnt, ticks, hold_left;

        vecs[0] = '{18'h00000, 20, 18'h00000, 18'h00000, 18'h00000, 0};
        vecs[1] = '{18'h2A5A5, 20, 18'h2A5A5, 18'h2A5A5, 18'h00000, 1};
        vecs[2] = '{18'h00000, 20, 18'h00000, 18'h00000, 18'h2A5A5, 1};
        vecs[3] = '{18'h3FFFF, 20, 18'h3FFFF, 18'h3FFFF, 18'h00000, 1};
        vecs[4] = '{18'h15A5A, 20, 18'h15A5A, 18'h00000, 18'h2A5A5, 1};
        vecs[5] = '{18'h2A5A5, 20, 18'h2A5A5, 18'h2A5A5, 18'h15A5A, 1};
        vecs[6] = '{18'h00000, 20, 18'h00000, 18'h00000, 18'h2A5A5, 1};

        // Reset held with all switches up: every output must stay 0.
        rstn   = 1'b0;
        sif.sw = 18'h3FFFF;
        repeat (3) step();
        check_all_zero("in_reset");

        // Release: tick in the 4th cycle and every 4 thereafter; held-high
        // switches debounce up from 0 after three ticks.
        rstn = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            check("release_tick", sif.sample_tick, (e % DIV == DIV - 1));
            check("release_db",   sif.sw_db,   (e >= 12) ? 18'h3FFFF : 18'h0);
            check("release_rise", sif.sw_rise, (e == 12) ? 18'h3FFFF : 18'h0);
        end

        sif.sw = '0;
        repeat (20) step();
        check("settled_low", sif.sw_db, '0);

        // Clean step on bit 0.
        sif.sw    = 18'h00001;
        lat       = 0;
        rise_cnt  = 0;
        others_or = '0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (sif.sw_db[0] && lat == 0) lat = n;
            rise_cnt  += int'(sif.sw_rise[0]);
            others_or |= {sif.sw_db[NSW-1:1], 1'b0} | {sif.sw_rise[NSW-1:1], 1'b0} | sif.sw_fall;
        end
        check("step_latency_min", (lat >= 2 + (SS - 1) * DIV), 1'b1);
        check("step_latency_max", (lat >= 1 && lat <= 2 + SS * DIV), 1'b1);
        check("step_rise_cycles", rise_cnt, 1);
        check("step_others_quiet", others_or, '0);
        sif.sw = '0;
        repeat (20) step();

        // Bounce on bit 5, phased so the short low gap covers a sample instant.
        for (int n = 0; n < DIV && (mdl_m % DIV) != DIV - 2; n++) step();
        check("bounce_phase", mdl_m % DIV, DIV - 2);
        bnc_db_seen    = 1'b0;
        bnc_pulse_seen = 1'b0;
        bounce_phase(1'b1, 6);
        bounce_phase(1'b0, 3);
        bounce_phase(1'b1, 6);
        bounce_phase(1'b0, 20);
        check("bounce_db_stays_low", bnc_db_seen, 1'b0);
        check("bounce_no_pulse",     bnc_pulse_seen, 1'b0);

        // Table-driven multi-bit steps.
        for (int v = 0; v < $size(vecs); v++) begin
            sif.sw  = vecs[v].sw;
            rise_or = '0;
            fall_or = '0;
            changes = 0;
            pulses  = 0;
            for (int n = 0; n < vecs[v].hold; n++) begin
                prev_db = sif.sw_db;
                step();
                if (sif.sw_db != prev_db) changes++;
                if ((sif.sw_rise | sif.sw_fall) != '0) pulses++;
                rise_or |= sif.sw_rise;
                fall_or |= sif.sw_fall;
            end
            check($sformatf("vec%0d_db", v),      sif.sw_db, vecs[v].exp_db);
            check($sformatf("vec%0d_rise", v),    rise_or,   vecs[v].exp_rise);
            check($sformatf("vec%0d_fall", v),    fall_or,   vecs[v].exp_fall);
            check($sformatf("vec%0d_changes", v), changes,   vecs[v].exp_changes);
            check($sformatf("vec%0d_pulses", v),  pulses,    vecs[v].exp_changes);
        end

        // Reset pulse after two sample instants of a rising bit 17.
        sif.sw = 18'h20000;
        ticks  = 0;
        for (int n = 0; n < 20 && ticks < 2; n++) begin
            step();
            if (mdl_tick) ticks++;
        end
        check("mid_ticks_seen", ticks, 2);
        rstn = 1'b0;
        step();
        check_all_zero("mid_reset");
        rstn = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            check("mid_db17",   sif.sw_db[17],   (e >= 12));
            check("mid_rise17", sif.sw_rise[17], (e == 12));
        end
        sif.sw = '0;
        repeat (20) step();

        // Randomized held levels, single-cycle glitches and rare resets.
        hold_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rstn = 1'b0;
                step();
                rstn = 1'b1;
            end else begin
                if (hold_left == 0) begin
                    sif.sw    = NSW'($urandom);
                    hold_left = $urandom_range(1, 24);
                end else begin
                    hold_left--;
                end
                if ($urandom_range(0, 7) == 0)
                    sif.sw[$urandom_range(0, NSW - 1)] ^= 1'b1;
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
